// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite register bank responder with independent write/read FSMs.
// Optional AXIL_REG_SLVERR_EN: out-of-range index returns SLVERR instead of aliasing modulo NUM_REGS.
module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t        w_state_q, w_state_d;
    r_state_t        r_state_q, r_state_d;
    logic [DW-1:0]   regs_q [NUM_REGS];
    logic [DW-1:0]   regs_d [NUM_REGS];
    logic [1:0]      bresp_q, bresp_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [IW-1:0]   aw_idx, ar_idx;
    int unsigned     w_sel, r_sel;
    logic            w_in_range, r_in_range;
    logic            w_hs, r_hs;
    logic            unused_ok;

    assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef AXIL_REG_SLVERR_EN
    assign w_sel      = 32'(aw_idx);
    assign r_sel      = 32'(ar_idx);
    assign w_in_range = 32'(aw_idx) < NUM_REGS;
    assign r_in_range = 32'(ar_idx) < NUM_REGS;
`else
    assign w_sel      = 32'(aw_idx) % NUM_REGS;
    assign r_sel      = 32'(ar_idx) % NUM_REGS;
    assign w_in_range = 1'b1;
    assign r_in_range = 1'b1;
`endif

    // Ready is combinational so a handshake plus response fits in two cycles.
    assign w_hs = S_AXI_ARESETN && (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign r_hs = S_AXI_ARESETN && (r_state_q == R_IDLE) && S_AXI_ARVALID;

    assign S_AXI_AWREADY = w_hs;
    assign S_AXI_WREADY  = w_hs;
    assign S_AXI_ARREADY = r_hs;
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        for (int k = 0; k < NUM_REGS; k++) regs_d[k] = regs_q[k];
        case (w_state_q)
            W_IDLE: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    bresp_d   = w_in_range ? 2'b00 : 2'b10;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (w_in_range && (w_sel == k)) begin
                            for (int b = 0; b < SW; b++) begin
                                if (S_AXI_WSTRB[b]) regs_d[k][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                            end
                        end
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read captures regs_q, so a same-cycle write to the same register is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (r_hs) begin
                    r_state_d = R_DATA;
                    rresp_d   = r_in_range ? 2'b00 : 2'b10;
                    rdata_d   = '0;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (r_in_range && (r_sel == k)) rdata_d = regs_q[k];
                    end
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
        end
    end
endmodule
